mips_control_fsm: RTL

Multicycle control unit for the IITK-Mini-MIPS core and the driving end of the ALU's `alu_op`/`alu_imm` interface. It fetches instruction words over a request/acknowledge handshake and decodes them into ALU operation codes. It sequences each instruction through decode, execute, memory and writeback states, and consumes the ALU's branch-condition bit and overflow flag to steer PC update, register writeback and trapping.

---
 rtl/mini_mips_pkg.sv | 48 ++++
 rtl/instr_decoder.sv | 56 +++++
 rtl/mips_control_fsm.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mini_mips_pkg.sv
// Shared constants and types for the IITK-Mini-MIPS control path:
// ALU op codes, opcodes, PC-select encodings, FSM state and instruction class.
package mini_mips_pkg;

  localparam logic [4:0] ALU_ADD = 5'h00;
  localparam logic [4:0] ALU_AND = 5'h01;
  localparam logic [4:0] ALU_OR  = 5'h02;
  localparam logic [4:0] ALU_NOT = 5'h03;
  localparam logic [4:0] ALU_XOR = 5'h04;
  localparam logic [4:0] ALU_SLL = 5'h05;
  localparam logic [4:0] ALU_SRL = 5'h06;
  localparam logic [4:0] ALU_SRA = 5'h07;
  localparam logic [4:0] ALU_EQ  = 5'h08;
  localparam logic [4:0] ALU_NE  = 5'h09;
  localparam logic [4:0] ALU_LT  = 5'h0a;
  localparam logic [4:0] ALU_GT  = 5'h0b;
  localparam logic [4:0] ALU_LE  = 5'h0c;
  localparam logic [4:0] ALU_GE  = 5'h0d;
  localparam logic [4:0] ALU_LTU = 5'h0e;
  localparam logic [4:0] ALU_GTU = 5'h0f;
  localparam logic [4:0] ALU_SUB = 5'h10;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h01;
  localparam logic [5:0] OP_SW    = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h08;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT, S_TRAP
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_LW, CLS_SW, CLS_BR, CLS_J, CLS_HALT, CLS_ILL
  } instr_class_e;

  // ALU codes are dense from ADD up to SUB; anything above is undefined.
  function automatic logic alu_code_valid(input logic [4:0] a);
    return a <= ALU_SUB;
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: opcode/funct fields to ALU op,
// immediate select, instruction class and illegal flag.
module instr_decoder
  import mini_mips_pkg::*;
(
  input  logic [5:0]   op_i,
  input  logic [5:0]   funct_i,
  output logic [4:0]   alu_op_o,
  output logic         alu_imm_o,
  output instr_class_e cls_o,
  output logic         illegal_o
);

  always_comb begin
    alu_op_o  = ALU_ADD;
    alu_imm_o = 1'b0;
    cls_o     = CLS_ILL;
    case (op_i)
      OP_RTYPE: begin
        if (funct_i[5] && alu_code_valid(funct_i[4:0])) begin
          cls_o    = CLS_ALU;
          alu_op_o = funct_i[4:0];
        end
      end
      OP_LW: begin
        cls_o     = CLS_LW;
        alu_imm_o = 1'b1;
      end
      OP_SW: begin
        cls_o     = CLS_SW;
        alu_imm_o = 1'b1;
      end
      OP_BEQ: begin
        cls_o    = CLS_BR;
        alu_op_o = ALU_EQ;
      end
      OP_BNE: begin
        cls_o    = CLS_BR;
        alu_op_o = ALU_NE;
      end
      OP_J:    cls_o = CLS_J;
      OP_HALT: cls_o = CLS_HALT;
      default: begin
        // I-type ALU: opcode is {1, alu code}
        if (op_i[5] && alu_code_valid(op_i[4:0])) begin
          cls_o     = CLS_ALU;
          alu_op_o  = op_i[4:0];
          alu_imm_o = 1'b1;
        end
      end
    endcase
  end

  assign illegal_o = (cls_o == CLS_ILL);

endmodule

// File: rtl/mips_control_fsm.sv
// Multicycle control FSM for IITK-Mini-MIPS. Define MIPS_OVERFLOW_TRAP_EN to
// trap on ADD/SUB overflow of ALU-class instructions instead of writing back.
module mips_control_fsm
  import mini_mips_pkg::*;
#(
  parameter int BUS_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] instr,
  output logic                 imem_req,
  input  logic                 imem_ack,
  output logic [BUS_WIDTH-1:0] ir,
  output logic [4:0]           alu_op,
  output logic                 alu_imm,
  input  logic                 alu_result0,
  input  logic                 alu_overflow,
  output logic                 pc_we,
  output logic [1:0]           pc_sel,
  output logic                 dmem_req,
  output logic                 dmem_we,
  input  logic                 dmem_ack,
  output logic                 rf_we,
  output logic                 rf_wdata_sel,
  output logic                 rf_waddr_sel,
  output logic                 halted,
  output logic                 trap
);

  state_e               state_q, state_d;
  logic [BUS_WIDTH-1:0] ir_q;
  logic [4:0]           alu_op_q;
  logic                 alu_imm_q;

  logic [4:0]   dec_alu_op;
  logic         dec_alu_imm;
  instr_class_e dec_cls;
  logic         dec_illegal;

  instr_decoder u_dec (
    .op_i      (ir_q[31:26]),
    .funct_i   (ir_q[5:0]),
    .alu_op_o  (dec_alu_op),
    .alu_imm_o (dec_alu_imm),
    .cls_o     (dec_cls),
    .illegal_o (dec_illegal)
  );

`ifndef MIPS_OVERFLOW_TRAP_EN
  logic ovf_unused;
  assign ovf_unused = alu_overflow;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (imem_ack) state_d = S_DECODE;
      S_DECODE: begin
        if (dec_illegal)                state_d = S_TRAP;
        else if (dec_cls == CLS_HALT)   state_d = S_HALT;
        else                            state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        case (dec_cls)
          CLS_ALU: begin
            state_d = S_WB;
`ifdef MIPS_OVERFLOW_TRAP_EN
            if (alu_overflow && (alu_op_q == ALU_ADD || alu_op_q == ALU_SUB))
              state_d = S_TRAP;
`endif
          end
          CLS_LW, CLS_SW: state_d = S_MEM;
          default:        state_d = S_FETCH;
        endcase
      end
      S_MEM:    if (dmem_ack) state_d = (dec_cls == CLS_LW) ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      alu_op_q  <= ALU_ADD;
      alu_imm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH && imem_ack) ir_q <= instr;
      if (state_q == S_DECODE) begin
        alu_op_q  <= dec_alu_op;
        alu_imm_q <= dec_alu_imm;
      end
    end
  end

  // Strobes are decoded from state and forced low while rst is held.
  logic in_exec;
  assign in_exec = !rst && (state_q == S_EXECUTE);

  always_comb begin
    imem_req     = !rst && (state_q == S_FETCH);
    pc_we        = (imem_req && imem_ack) ||
                   (in_exec && ((dec_cls == CLS_BR && alu_result0) || dec_cls == CLS_J));
    pc_sel       = PC_PLUS4;
    if (in_exec && dec_cls == CLS_J)       pc_sel = PC_JUMP;
    else if (in_exec && dec_cls == CLS_BR) pc_sel = PC_BRANCH;
    dmem_req     = !rst && (state_q == S_MEM);
    dmem_we      = dmem_req && (dec_cls == CLS_SW);
    rf_we        = !rst && (state_q == S_WB);
    rf_wdata_sel = rf_we && (dec_cls == CLS_LW);
    rf_waddr_sel = rf_we && (ir_q[31:26] == OP_RTYPE);
    halted       = !rst && (state_q == S_HALT);
    trap         = !rst && (state_q == S_TRAP);
  end

  assign ir      = ir_q;
  assign alu_op  = alu_op_q;
  assign alu_imm = alu_imm_q;

endmodule
